// File: rtl/tiny_pll_loop_ctrl_if.sv
// Bundle of the loop controller's data-path signals: the PFD inputs and
// enable going in, the DCO control word, update strobe, lock and PFD
// debug state coming out. The clock and reset are not part of it.
interface tiny_pll_loop_ctrl_if;
  logic       enable;
  logic       ref_in;
  logic       fb_in;
  logic [7:0] ctrl_word;
  logic       upd;
  logic       lock;
  logic       up;
  logic       dn;

  // Side that drives the loop (PLL top level or a testbench)
  modport master (
    output enable, ref_in, fb_in,
    input  ctrl_word, upd, lock, up, dn
  );

  // Side implemented by the loop controller itself
  modport slave (
    input  enable, ref_in, fb_in,
    output ctrl_word, upd, lock, up, dn
  );
endinterface

// File: rtl/tiny_pll_loop_ctrl.sv
// Digital phase/frequency detector with a PI loop filter and lock detector.
// ref_in and fb_in are synchronised and edge-detected. A small FSM measures
// the cycle distance between matching edges, giving a signed error. Each
// "close" of a comparison updates the 8.4 integrator, the DCO control word
// and the lock flag.
module tiny_pll_loop_ctrl #(
  parameter int KP_SHIFT   = 2,
  parameter int KI_SHIFT   = 0,
  parameter int CTRL_INIT  = 128,
  parameter int LOCK_TOL   = 2,
  parameter int LOCK_COUNT = 4
) (
  input logic                 clk,
  input logic                 rst,
  tiny_pll_loop_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DN} state_t;

  localparam logic [7:0]  LP_TOL      = 8'(LOCK_TOL);
  localparam logic [7:0]  LP_LOCK_CNT = 8'(LOCK_COUNT);
  localparam logic [7:0]  LP_CTRL_INIT  = 8'(CTRL_INIT);
  localparam logic [11:0] LP_INTEG_INIT = 12'(CTRL_INIT * 16);

  logic [2:0]        r_refSync, r_fbSync;
  state_t            r_state, w_stateNext;
  logic [6:0]        r_cnt, w_cntNext, w_cntInc;
  logic [11:0]       r_integ, w_integNew;
  logic [7:0]        r_ctrl, w_ctrlNew;
  logic [7:0]        r_goodCnt, w_goodInc;
  logic              r_lock, r_upd;
  logic              w_refE, w_fbE, w_close, w_inTol;
  logic signed [7:0] w_err;
  logic [7:0]        w_absErr;
  logic signed [12:0] w_errExt, w_iStep, w_pStep;
  logic signed [13:0] w_integSum, w_ctrlSum;

  // Two flops of metastability protection plus one flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_refSync <= '0;
      r_fbSync  <= '0;
    end else begin
      r_refSync <= {r_refSync[1:0], bus.ref_in};
      r_fbSync  <= {r_fbSync[1:0], bus.fb_in};
    end
  end

  assign w_refE = r_refSync[1] & ~r_refSync[2];
  assign w_fbE  = r_fbSync[1] & ~r_fbSync[2];

  // PFD next state: count cycles between the leading and lagging edge
  // and close with a signed error. A second leading edge before the lagging
  // one is a frequency error and closes at full scale.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_close     = 1'b0;
    w_err       = 8'sd0;
    w_cntInc    = (r_cnt == 7'd127) ? r_cnt : r_cnt + 7'd1;
    if (!bus.enable) begin
      w_stateNext = S_IDLE;
      w_cntNext   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_refE && w_fbE) begin
            w_close = 1'b1;
          end else if (w_refE) begin
            w_stateNext = S_UP;
            w_cntNext   = 7'd1;
          end else if (w_fbE) begin
            w_stateNext = S_DN;
            w_cntNext   = 7'd1;
          end
        end
        S_UP: begin
          if (w_fbE) begin
            w_close = 1'b1;
            w_err   = $signed({1'b0, r_cnt});
            if (w_refE) begin
              w_cntNext = 7'd1;
            end else begin
              w_stateNext = S_IDLE;
              w_cntNext   = '0;
            end
          end else if (w_refE) begin
            w_close   = 1'b1;
            w_err     = 8'sd127;
            w_cntNext = 7'd1;
          end else begin
            w_cntNext = w_cntInc;
          end
        end
        S_DN: begin
          if (w_refE) begin
            w_close = 1'b1;
            w_err   = -$signed({1'b0, r_cnt});
            if (w_fbE) begin
              w_cntNext = 7'd1;
            end else begin
              w_stateNext = S_IDLE;
              w_cntNext   = '0;
            end
          end else if (w_fbE) begin
            w_close   = 1'b1;
            w_err     = -8'sd127;
            w_cntNext = 7'd1;
          end else begin
            w_cntNext = w_cntInc;
          end
        end
        default: begin
          w_stateNext = S_IDLE;
          w_cntNext   = '0;
        end
      endcase
    end
  end

  // PFD state and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  // PI filter arithmetic: integrator first, then the proportional term is
  // added to the integer part of the freshly updated integrator
  always_comb begin
    w_errExt   = 13'(w_err);
    w_iStep    = w_errExt >>> KI_SHIFT;
    w_pStep    = w_errExt >>> KP_SHIFT;
    w_integSum = $signed({2'b00, r_integ}) + 14'(w_iStep);
    if (w_integSum < 14'sd0)
      w_integNew = '0;
    else if (w_integSum > 14'sd4095)
      w_integNew = 12'hFFF;
    else
      w_integNew = w_integSum[11:0];
    w_ctrlSum = $signed({6'b000000, w_integNew[11:4]}) + 14'(w_pStep);
    if (w_ctrlSum < 14'sd0)
      w_ctrlNew = '0;
    else if (w_ctrlSum > 14'sd255)
      w_ctrlNew = 8'hFF;
    else
      w_ctrlNew = w_ctrlSum[7:0];
    w_absErr  = w_err[7] ? 8'(-w_err) : w_err;
    w_inTol   = (w_absErr <= LP_TOL);
    w_goodInc = (r_goodCnt >= LP_LOCK_CNT) ? LP_LOCK_CNT : r_goodCnt + 8'd1;
  end

  // Filter, lock detector and update strobe; integrator and control word
  // simply hold while the loop is disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_integ   <= LP_INTEG_INIT;
      r_ctrl    <= LP_CTRL_INIT;
      r_goodCnt <= '0;
      r_lock    <= 1'b0;
      r_upd     <= 1'b0;
    end else begin
      r_upd <= w_close;
      if (!bus.enable) begin
        r_goodCnt <= '0;
        r_lock    <= 1'b0;
      end else if (w_close) begin
        r_integ <= w_integNew;
        r_ctrl  <= w_ctrlNew;
        if (w_inTol) begin
          r_goodCnt <= w_goodInc;
          r_lock    <= (w_goodInc == LP_LOCK_CNT);
        end else begin
          r_goodCnt <= '0;
          r_lock    <= 1'b0;
        end
      end
    end
  end

  assign bus.ctrl_word = r_ctrl;
  assign bus.upd       = r_upd;
  assign bus.lock      = r_lock;
  assign bus.up        = (r_state == S_UP);
  assign bus.dn        = (r_state == S_DN);

endmodule
